sevseg_scan_mux: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display (score/level panel).

---
 rtl/sevseg_pkg.sv | 51 +++++
 rtl/sevseg_glyph_dec.sv | 12 +
 rtl/sevseg_scan_mux.sv | 155 +++++++++++++++
 tb/tb_sevseg_scan_mux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared segment encodings and the nibble-to-glyph decode function for the scan driver.
package sevseg_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active low

  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_A     = 7'h08;
  localparam seg_t SEG_B     = 7'h03;
  localparam seg_t SEG_C     = 7'h46;
  localparam seg_t SEG_D     = 7'h21;
  localparam seg_t SEG_E     = 7'h06;
  localparam seg_t SEG_F     = 7'h0E;
  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t glyph(input logic [3:0] v, input logic hex);
    seg_t s;
    s = SEG_BLANK;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    // Decimal mode has no glyph above 9, so those values show a dash.
    if (!hex && (v > 4'd9)) s = SEG_DASH;
    return s;
  endfunction

endpackage

// File: rtl/sevseg_glyph_dec.sv
// Combinational nibble decoder: hex_mode selects A-F glyphs, otherwise 10..15 show a dash.
module sevseg_glyph_dec
  import sevseg_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_hex_mode,
  output seg_t       o_seg
);

  assign o_seg = glyph(i_value, i_hex_mode);

endmodule

// File: rtl/sevseg_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with per-frame input snapshot and PWM dimming.
// Optional digit blinking is compiled in when SEVSEG_BLINK_EN is defined.
module sevseg_scan_mux
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV_W    = 18,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || BRIGHT_W >= CLK_DIV_W || BLINK_FRAMES < 1) begin : g_bad_params
    $error("sevseg_scan_mux: illegal parameter combination");
  end

  logic [CLK_DIV_W-1:0]    r_div_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_first;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_hex;
  logic                    r_lz;
  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_start;

  logic                    w_tick;
  logic                    w_snap;
  logic                    w_blank;
  logic                    w_hide;
  logic                    w_pwm_on;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_lead_zero;
  seg_t                    w_glyph;

  assign w_tick = &r_div_cnt;
  assign w_snap = r_first | (w_tick & (r_idx == LAST_IDX));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
      r_first   <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + CLK_DIV_W'(1);
      r_first   <= 1'b0;
      if (w_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // NOTE: shadow registers are reset so the cycle before the first snapshot decodes a defined value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_hex    <= 1'b0;
      r_lz     <= 1'b0;
    end else if (w_snap) begin
      r_digits <= digits_in;
      r_dp     <= dp_in;
      r_hex    <= hex_mode;
      r_lz     <= lz_blank;
    end
  end

  // NOTE: the whole vector gets a default first so no path through the loop can infer a latch.
  always_comb begin
    w_lead_zero                 = '0;
    w_lead_zero[NUM_DIGITS-1]   = (r_digits[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] & (r_digits[4*i +: 4] == 4'd0);
    end
  end

  assign w_nibble = r_digits[4*r_idx +: 4];
  assign w_blank  = r_lz & w_lead_zero[r_idx] & (r_idx != '0);
  assign w_pwm_on = (r_div_cnt[CLK_DIV_W-1 -: BRIGHT_W] <= brightness);

  sevseg_glyph_dec u_glyph_dec (
    .i_value    (w_nibble),
    .i_hex_mode (r_hex),
    .o_seg      (w_glyph)
  );

`ifdef SEVSEG_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]       r_frame_cnt;
  logic                  r_blink_off;
  logic [NUM_DIGITS-1:0] r_blink_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt  <= '0;
      r_blink_off  <= 1'b0;
      r_blink_mask <= '0;
    end else begin
      if (w_snap) r_blink_mask <= blink_mask;
      if (w_tick && (r_idx == LAST_IDX)) begin
        if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
      end
    end
  end

  assign w_hide = r_blink_off & r_blink_mask[r_idx];
`else
  assign w_hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg         <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_an          <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_seg         <= (w_blank | w_hide) ? SEG_BLANK : w_glyph;
      r_dp_n        <= ~r_dp[r_idx] | w_hide;
      // All anodes dark on the tick cycle so the old pattern never ghosts onto the next digit.
      r_an          <= (w_pwm_on & ~w_tick) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_frame_start <= w_snap;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp_n;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// Self-checking bench for sevseg_scan_mux: cycle scoreboard plus directed frame, blanking, PWM and reset checks.
module tb_sevseg_scan_mux;

  localparam int NUM_DIGITS = 4;
  localparam int CLK_DIV_W  = 4;
  localparam int BRIGHT_W   = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        lz_blank;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  // Reference model state
  int          m_cnt;
  int          m_idx;
  bit          m_first;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_hex;
  logic        m_lz;
  logic [3:0]  m_v;
  bit          m_tick;
  bit          m_snap;
  exp_t        m_e;
  exp_t        c_e;

  always #5 clk = ~clk;

  sevseg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_DIV_W  (CLK_DIV_W),
    .BRIGHT_W   (BRIGHT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .hex_mode    (hex_mode),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
`ifdef SEVSEG_BLINK_EN
    .blink_mask  (4'b0000),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: on each edge predict the registered outputs from pre-edge state, then advance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_idx   = 0;
      m_first = 1'b1;
      m_dig   = '0;
      m_dp    = '0;
      m_hex   = 1'b0;
      m_lz    = 1'b0;
      sb_q.delete();
    end else begin
      m_tick = (m_cnt == 15);
      m_snap = m_first || (m_tick && m_idx == NUM_DIGITS - 1);
      m_v    = m_dig[4*m_idx +: 4];
      m_e.seg = (!m_hex && m_v > 4'd9) ? 7'h3F : GLYPH[m_v];
      if (m_lz && m_idx != 0 && (m_dig >> (4*m_idx)) == 16'd0) m_e.seg = 7'h7F;
      m_e.dp = ~m_dp[m_idx];
      m_e.an = (!m_tick && (m_cnt >> 2) <= int'(brightness)) ? ~(4'b0001 << m_idx) : 4'b1111;
      m_e.fs = m_snap;
      sb_q.push_back(m_e);
      if (m_snap) begin
        m_dig = digits_in;
        m_dp  = dp_in;
        m_hex = hex_mode;
        m_lz  = lz_blank;
      end
      m_first = 1'b0;
      if (m_tick) m_idx = (m_idx + 1) % NUM_DIGITS;
      m_cnt = (m_cnt + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (!rst_n || sb_q.size() == 0) begin
      check("rst_an",  32'(an),          32'hF);
      check("rst_seg", 32'(seg),         32'h7F);
      check("rst_dp",  32'(dp),          32'h1);
      check("rst_fs",  32'(frame_start), 32'h0);
    end else begin
      c_e = sb_q.pop_front();
      check("sb_an",  32'(an),          32'(c_e.an));
      check("sb_seg", 32'(seg),         32'(c_e.seg));
      check("sb_dp",  32'(dp),          32'(c_e.dp));
      check("sb_fs",  32'(frame_start), 32'(c_e.fs));
    end
  end

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 400);
    if (frame_start !== 1'b1) check("wait_fs_timeout", 32'(frame_start), 32'h1);
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== pat && n < 400);
    if (an !== pat) check("wait_an_timeout", 32'(an), 32'(pat));
  endtask

  // Waits for a fresh snapshot, then checks each digit's seg/dp when its anode is on.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    wait_fs();
    for (int i = 0; i < NUM_DIGITS; i++) begin
      wait_an(~(4'b0001 << i));
      check($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(segs[7*i +: 7]));
      check($sformatf("%s_dp%0d", tag, i),  32'(dp),  32'(dps[i]));
    end
  endtask

  task automatic count_lit(input string tag, input int exp_lit);
    int lit;
    lit = 0;
    wait_fs();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (an !== 4'hF) lit++;
    end
    check(tag, 32'(lit), 32'(exp_lit));
  endtask

  initial begin
    rst_n      = 1'b0;
    digits_in  = 16'h4321;
    dp_in      = 4'b0000;
    hex_mode   = 1'b1;
    lz_blank   = 1'b0;
    brightness = 2'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: scan order, glyphs and immediate snapshot after release
    @(negedge clk);
    check("t1_first_an", 32'(an), 32'hE);
    check("t1_first_fs", 32'(frame_start), 32'h1);
    check_frame("t1", {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF);

    // 2: mid-frame change stays invisible until the next frame
    wait_fs();
    wait_an(4'b1101);
    digits_in = 16'h9999;
    wait_an(4'b1011);
    check("t2_old_d2", 32'(seg), 32'h30);
    wait_an(4'b0111);
    check("t2_old_d3", 32'(seg), 32'h19);
    check_frame("t2", {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF);

    // 3: hex vs decimal decode and leading-zero blanking
    digits_in = 16'h00A7;
    check_frame("t3_hex", {7'h40, 7'h40, 7'h08, 7'h78}, 4'hF);
    hex_mode = 1'b0;
    check_frame("t3_dec", {7'h40, 7'h40, 7'h3F, 7'h78}, 4'hF);
    hex_mode = 1'b1;
    lz_blank = 1'b1;
    check_frame("t3_lz", {7'h7F, 7'h7F, 7'h08, 7'h78}, 4'hF);

    // 4: all zeros blanked except digit 0; dp survives blanking
    digits_in = 16'h0000;
    dp_in     = 4'b0100;
    check_frame("t4", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011);
    dp_in     = 4'b0000;
    lz_blank  = 1'b0;
    digits_in = 16'h4321;

    // 5: PWM duty per 64-cycle frame
    brightness = 2'd0;
    count_lit("t5_lit_b0", 16);
    brightness = 2'd1;
    count_lit("t5_lit_b1", 32);
    brightness = 2'd3;
    count_lit("t5_lit_b3", 60);

    // 6: asynchronous reset mid-slot, then restart at digit 0
    wait_an(4'b1101);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_an",  32'(an),  32'hF);
    check("t6_async_seg", 32'(seg), 32'h7F);
    check("t6_async_dp",  32'(dp),  32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_restart_an", 32'(an), 32'hE);
    check("t6_restart_fs", 32'(frame_start), 32'h1);
    check_frame("t6", {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
